// File: rtl/demux4_tdm.sv
// demux4_tdm: 4-slot TDM frame demultiplexer with atomic shadow update; optional err_cnt via DEMUX4_TDM_ERR_CNT_EN
module demux4_tdm #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic           in_sof,
    input  logic [W-1:0]   in_data,
    output logic [4*W-1:0] y,
    output logic           y_valid,
    output logic [1:0]     s,
`ifdef DEMUX4_TDM_ERR_CNT_EN
    output logic [7:0]     err_cnt,
`endif
    output logic           slot_err
);
    typedef enum logic {HUNT, COLLECT} state_t;
    state_t state_q, state_d;
    logic [1:0] s_q, s_d;
    logic [W-1:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
    logic [4*W-1:0] y_q, y_d;
    logic y_valid_q, y_valid_d, slot_err_q, slot_err_d;
    always_comb begin
        state_d = state_q;
        s_d = s_q;
        sh0_d = sh0_q;
        sh1_d = sh1_q;
        sh2_d = sh2_q;
        y_d = y_q;
        y_valid_d = 1'b0;
        slot_err_d = 1'b0;
        if (in_valid && in_sof) begin
            slot_err_d = state_q == COLLECT;
            sh0_d = in_data;
            s_d = 2'd1;
            state_d = COLLECT;
        end else if (in_valid && state_q == COLLECT) begin
            sh1_d = s_q == 2'd1 ? in_data : sh1_q;
            sh2_d = s_q == 2'd2 ? in_data : sh2_q;
            // slot index wraps 3 -> 0 as the frame completes
            s_d = s_q + 2'd1;
            if (s_q == 2'd3) begin
                y_d = {in_data, sh2_q, sh1_q, sh0_q};
                y_valid_d = 1'b1;
                state_d = HUNT;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HUNT;
            s_q <= '0;
            sh0_q <= '0;
            sh1_q <= '0;
            sh2_q <= '0;
            y_q <= '0;
            y_valid_q <= 1'b0;
            slot_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q <= s_d;
            sh0_q <= sh0_d;
            sh1_q <= sh1_d;
            sh2_q <= sh2_d;
            y_q <= y_d;
            y_valid_q <= y_valid_d;
            slot_err_q <= slot_err_d;
        end
    end
    assign y = y_q;
    assign y_valid = y_valid_q;
    assign s = s_q;
    assign slot_err = slot_err_q;
`ifdef DEMUX4_TDM_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    always_comb err_cnt_d = err_cnt_q + 8'(slot_err_d && err_cnt_q != 8'hff);
    always_ff @(posedge clk) begin
        if (!rst_n) err_cnt_q <= '0;
        else err_cnt_q <= err_cnt_d;
    end
    assign err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_demux4_tdm.sv
// tb_demux4_tdm: scoreboard bench for demux4_tdm; err_cnt checks under DEMUX4_TDM_ERR_CNT_EN
module tb_demux4_tdm;
    logic clk, rst_n, in_valid, in_sof;
    logic [7:0] in_data;
    logic [31:0] y;
    logic y_valid, slot_err;
    logic [1:0] s;
    int checks = 0, errors = 0;
    logic [31:0] yq[$];
    int eq[$];
`ifdef DEMUX4_TDM_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif
    demux4_tdm #(.W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_data(in_data), .y(y), .y_valid(y_valid), .s(s),
`ifdef DEMUX4_TDM_ERR_CNT_EN
        .err_cnt(err_cnt),
`endif
        .slot_err(slot_err)
    );
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(negedge clk) begin
        if (y_valid) begin
            checks++;
            if (yq.size() == 0) begin
                errors++;
                $display("FAIL y_valid_unexpected y=%h", y);
            end else begin
                logic [31:0] e;
                e = yq.pop_front();
                if (y !== e) begin
                    errors++;
                    $display("FAIL frame_y got=%h exp=%h", y, e);
                end
            end
        end
        if (slot_err) begin
            checks++;
            if (eq.size() == 0) begin
                errors++;
                $display("FAIL slot_err_unexpected t=%0t", $time);
            end else void'(eq.pop_front());
        end
    end
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask
    task automatic beat(input logic sof, input logic [7:0] d);
        in_valid = 1'b1;
        in_sof = sof;
        in_data = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof = 1'b0;
    endtask
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_sof = 1'b0;
        in_data = '0;
        idle(2);
        rst_n = 1'b1;
        chk("rst_y", y, 0);
        chk("rst_yv", y_valid, 0);
        chk("rst_s", s, 0);
        chk("rst_err", slot_err, 0);
`ifdef DEMUX4_TDM_ERR_CNT_EN
        chk("rst_cnt", err_cnt, 0);
`endif
        // clean frame
        beat(1, 8'hA0);
        beat(0, 8'hB1);
        beat(0, 8'hC2);
        yq.push_back(32'hD3C2B1A0);
        beat(0, 8'hD3);
        chk("clean_yv", y_valid, 1);
        chk("clean_y", y, 32'hD3C2B1A0);
        chk("clean_s", s, 0);
        idle(1);
        chk("clean_yv_pulse", y_valid, 0);
        // gapped frame
        beat(1, 8'hA0);
        chk("gap_s1", s, 1);
        idle(2);
        beat(0, 8'hB1);
        chk("gap_s2", s, 2);
        idle(2);
        beat(0, 8'hC2);
        chk("gap_s3", s, 3);
        chk("gap_hold", y, 32'hD3C2B1A0);
        idle(2);
        yq.push_back(32'hD3C2B1A0);
        beat(0, 8'hD3);
        chk("gap_s0", s, 0);
        chk("gap_yv", y_valid, 1);
        idle(2);
        // hunt discard
        beat(0, 8'h11);
        beat(0, 8'h22);
        chk("hunt_s", s, 0);
        beat(1, 8'h01);
        beat(0, 8'h02);
        beat(0, 8'h03);
        yq.push_back(32'h04030201);
        beat(0, 8'h04);
        chk("hunt_y", y, 32'h04030201);
        idle(1);
        // premature start of frame
        beat(1, 8'h10);
        beat(0, 8'h20);
        eq.push_back(1);
        beat(1, 8'h30);
        chk("pre_s", s, 1);
        chk("pre_err", slot_err, 1);
        chk("pre_y_hold", y, 32'h04030201);
`ifdef DEMUX4_TDM_ERR_CNT_EN
        chk("pre_cnt", err_cnt, 1);
`endif
        beat(0, 8'h40);
        beat(0, 8'h50);
        yq.push_back(32'h60504030);
        beat(0, 8'h60);
        chk("pre_y", y, 32'h60504030);
        idle(1);
        // reset mid-frame, with a sof beat offered during reset
        beat(1, 8'h0A);
        beat(0, 8'h0B);
        rst_n = 1'b0;
        beat(1, 8'h99);
        rst_n = 1'b1;
        chk("mid_rst_s", s, 0);
        chk("mid_rst_y", y, 0);
`ifdef DEMUX4_TDM_ERR_CNT_EN
        chk("mid_rst_cnt", err_cnt, 0);
`endif
        beat(0, 8'h0C);
        beat(0, 8'h0D);
        beat(0, 8'h0E);
        beat(0, 8'h0F);
        chk("mid_s", s, 0);
        chk("mid_y", y, 0);
        idle(1);
        // sof on slot 3 restarts the frame instead of completing it
        beat(1, 8'h01);
        beat(0, 8'h02);
        beat(0, 8'h03);
        eq.push_back(1);
        beat(1, 8'h04);
        chk("b2b_s", s, 1);
        chk("b2b_yv", y_valid, 0);
        chk("b2b_hold", y, 0);
        beat(0, 8'h05);
        beat(0, 8'h06);
        yq.push_back(32'h07060504);
        beat(0, 8'h07);
        chk("b2b_y", y, 32'h07060504);
        idle(1);
        // 300 consecutive sof beats
        for (int i = 0; i < 300; i++) begin
            if (i > 0) eq.push_back(1);
            beat(1, 8'(i));
        end
        chk("sat_s", s, 1);
`ifdef DEMUX4_TDM_ERR_CNT_EN
        chk("sat_cnt", err_cnt, 255);
`endif
        idle(3);
        chk("yq_drained", yq.size(), 0);
        chk("eq_drained", eq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
